// File: rtl/ads1675_tx_emulator_if.sv
// Sample-feed handshake into the ADS1675 transmit emulator.
interface ads1675_tx_emulator_if #(
  parameter int DW = 24
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/ads1675_tx_emulator.sv
// ADS1675 serial-output emulator: sclk/drdy/dout frames from handshaked samples.
// Optional ADS1675_EMU_RAMP_EN replaces s_data with an internal per-frame ramp.
module ads1675_tx_emulator #(
  parameter int DW         = 24,
  parameter int SCLK_DIV   = 2,
  parameter int FRAME_SCLK = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic        pown,
  input  logic        cs_n,
  ads1675_tx_emulator_if.slave s,
  output logic        sclk,
  output logic        drdy,
  output logic        dout,
  output logic        underrun,
  output logic [15:0] frame_cnt
);
  localparam int BW   = $clog2(FRAME_SCLK);
  localparam int DIVW = $clog2(SCLK_DIV + 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(FRAME_SCLK - 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SCLK_DIV - 1);

  logic            sclk_q, sclk_d;
  logic            drdy_q, drdy_d;
  logic            dout_q, dout_d;
  logic            underrun_q, underrun_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;

  logic          run, tick, rise, fstart;
  logic          src_ok;
  logic [DW-1:0] src, nxt, shifted;
  logic [BW-1:0] bit_nx;

  assign run    = en & start & pown;
  assign tick   = (div_cnt_q == DIV_LAST);
  assign rise   = run & tick & ~sclk_q;
  assign fstart = rise & (bit_cnt_q == BIT_LAST);
  // Ready is the decode of the cycle just before the frame-start edge.
  assign s.s_ready = fstart & ~rst;

`ifdef ADS1675_EMU_RAMP_EN
  logic [DW-1:0] ramp_q, ramp_d;
  logic          unused_src;
  assign unused_src = ^{s.s_data, s.s_valid};
  assign src    = ramp_q;
  assign src_ok = 1'b1;
`else
  assign src    = s.s_data;
  assign src_ok = s.s_valid;
`endif

  always_comb begin
    sclk_d      = sclk_q;
    drdy_d      = drdy_q;
    dout_d      = dout_q;
    underrun_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    hold_d      = hold_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    nxt         = hold_q;
    bit_nx      = bit_cnt_q + 1'b1;
    // Bits past DW shift out as zero, giving the idle tail of the frame.
    shifted     = hold_q << bit_nx;
`ifdef ADS1675_EMU_RAMP_EN
    ramp_d      = ramp_q;
`endif
    if (!run) begin
      sclk_d      = 1'b0;
      drdy_d      = 1'b0;
      dout_d      = 1'b0;
      frame_cnt_d = '0;
      div_cnt_d   = '0;
      bit_cnt_d   = BIT_LAST;
`ifdef ADS1675_EMU_RAMP_EN
      ramp_d      = '0;
`endif
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      if (tick) sclk_d = ~sclk_q;
      if (fstart) begin
        nxt         = src_ok ? src : hold_q;
        hold_d      = nxt;
        underrun_d  = ~src_ok;
        drdy_d      = 1'b1;
        dout_d      = nxt[DW-1] & ~cs_n;
        bit_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef ADS1675_EMU_RAMP_EN
        ramp_d      = ramp_q + 1'b1;
`endif
      end else if (rise) begin
        bit_cnt_d = bit_nx;
        drdy_d    = 1'b0;
        dout_d    = shifted[DW-1] & ~cs_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q      <= 1'b0;
      drdy_q      <= 1'b0;
      dout_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
      hold_q      <= '0;
      div_cnt_q   <= '0;
      bit_cnt_q   <= BIT_LAST;
`ifdef ADS1675_EMU_RAMP_EN
      ramp_q      <= '0;
`endif
    end else begin
      sclk_q      <= sclk_d;
      drdy_q      <= drdy_d;
      dout_q      <= dout_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
      hold_q      <= hold_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
`ifdef ADS1675_EMU_RAMP_EN
      ramp_q      <= ramp_d;
`endif
    end
  end

  assign sclk      = sclk_q;
  assign drdy      = drdy_q;
  assign dout      = dout_q;
  assign underrun  = underrun_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_ads1675_tx_emulator.sv
// Bench for ads1675_tx_emulator: vector table + scoreboard monitor + corner sequences.
module tb_ads1675_tx_emulator;
  localparam int DW = 24, SCLK_DIV = 2, FRAME_SCLK = 32;

  logic clk = 1'b0;
  logic rst, en, start, pown, cs_n;
  logic sclk, drdy, dout, underrun;
  logic [15:0] frame_cnt;

  ads1675_tx_emulator_if #(.DW(DW)) sif ();

  ads1675_tx_emulator #(.DW(DW), .SCLK_DIV(SCLK_DIV), .FRAME_SCLK(FRAME_SCLK)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .pown(pown), .cs_n(cs_n),
    .s(sif.slave), .sclk(sclk), .drdy(drdy), .dout(dout),
    .underrun(underrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct { logic [DW-1:0] word; logic und; } exp_t;
  typedef struct {
    logic [DW-1:0] data; logic valid; logic csn;
    logic [DW-1:0] exp_word; logic exp_und;
  } vec_t;

  exp_t sbq[$];
  bit   mon_en = 1'b0;

  // Monitor: decodes frames off sclk rises and scores them against the queue.
  logic          sclk_p = 1'b0, tail_or = 1'b0;
  logic [DW-1:0] shreg = '0;
  int            rdy_cnt = 0, dcnt = 0, nbits = 0, cyc = 0, last_fs = -1, und_total = 0;
  bit            in_frame = 1'b0, cur_ok = 1'b0;
  exp_t          cur;

  always begin
    @(posedge clk); #1;
    cyc++;
    if (rst || !(en && start && pown)) begin
      sclk_p = 1'b0; rdy_cnt = 0; in_frame = 1'b0; last_fs = -1; nbits = 0;
    end else begin
      if (sclk && !sclk_p) begin
        if (drdy) begin
          if (mon_en) begin
            chk("s_ready_pulses", rdy_cnt, 1);
            if (last_fs >= 0) chk("frame_period", cyc - last_fs, 128);
            if (in_frame) chk("tail_zero", {31'd0, tail_or}, 0);
            if (sbq.size() == 0) begin
              chk("sb_unexpected_frame", 1, 0);
              cur_ok = 1'b0;
            end else begin
              cur = sbq.pop_front();
              cur_ok = 1'b1;
              chk("underrun_at_start", {31'd0, underrun}, {31'd0, cur.und});
            end
          end
          rdy_cnt = 0; last_fs = cyc; dcnt = 0; tail_or = 1'b0; in_frame = 1'b1;
          shreg = {{(DW-1){1'b0}}, dout}; nbits = 1;
        end else if (in_frame) begin
          nbits++;
          if (nbits <= DW) shreg = {shreg[DW-2:0], dout};
          else tail_or = tail_or | dout;
          if (nbits == 2 && mon_en) chk("drdy_width", dcnt, 4);
          if (nbits == DW && mon_en && cur_ok) chk("frame_word", {8'd0, shreg}, {8'd0, cur.word});
        end
      end
      if (sif.s_ready) rdy_cnt++;
      if (drdy) dcnt++;
      if (underrun) und_total++;
      sclk_p = sclk;
    end
  end

  task automatic wait_fs(output int cycles, output bit ok);
    ok = 1'b0; cycles = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (drdy) begin ok = 1'b1; cycles = i; break; end
    end
    if (!ok) chk("frame_start_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t vecs[5];
  exp_t e;
  int   cyc_w, sclk_ones;
  bit   ok;

  initial begin
    vecs[0] = '{24'hA5C3F0, 1'b1, 1'b0, 24'hA5C3F0, 1'b0};
    vecs[1] = '{24'hFFFFFF, 1'b1, 1'b1, 24'h000000, 1'b0};
    vecs[2] = '{24'h000001, 1'b1, 1'b0, 24'h000001, 1'b0};
    vecs[3] = '{24'h123456, 1'b0, 1'b0, 24'h000001, 1'b1};
    vecs[4] = '{24'h800000, 1'b1, 1'b0, 24'h800000, 1'b0};

    // Reset dominates a live run request.
    rst = 1'b1; en = 1'b1; start = 1'b1; pown = 1'b1; cs_n = 1'b0;
    sif.s_data = 24'hA5C3F0; sif.s_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclk", {31'd0, sclk}, 0);
    chk("rst_drdy", {31'd0, drdy}, 0);
    chk("rst_dout", {31'd0, dout}, 0);
    chk("rst_s_ready", {31'd0, sif.s_ready}, 0);
    chk("rst_underrun", {31'd0, underrun}, 0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);

    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) repeat (100) @(negedge clk);
      sif.s_data = vecs[i].data; sif.s_valid = vecs[i].valid; cs_n = vecs[i].csn;
`ifdef ADS1675_EMU_RAMP_EN
      e.word = vecs[i].csn ? '0 : DW'(i); e.und = 1'b0;
`else
      e.word = vecs[i].exp_word; e.und = vecs[i].exp_und;
`endif
      sbq.push_back(e);
      if (i == 0) rst = 1'b0;
      wait_fs(cyc_w, ok);
      if (i == 0) begin
        chk("first_frame_latency", cyc_w, 2);
        chk("frame_cnt_first", {16'd0, frame_cnt}, 1);
      end
    end
    chk("frame_cnt_after_table", {16'd0, frame_cnt}, 5);
    repeat (100) @(negedge clk);
    mon_en = 1'b0;
`ifdef ADS1675_EMU_RAMP_EN
    chk("underrun_total", und_total, 0);
`else
    chk("underrun_total", und_total, 1);
`endif

    // Abort mid-frame at bit 10, then re-enter and retransmit the held sample.
    sif.s_data = 24'hFFFFFF; sif.s_valid = 1'b1; cs_n = 1'b0;
    wait_fs(cyc_w, ok);
    wait_fs(cyc_w, ok);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_sclk", {31'd0, sclk}, 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort_sclk", {31'd0, sclk}, 0);
    chk("abort_drdy", {31'd0, drdy}, 0);
    chk("abort_dout", {31'd0, dout}, 0);
    chk("abort_frame_cnt", {16'd0, frame_cnt}, 0);
    repeat (5) @(negedge clk);
    sif.s_valid = 1'b0; sif.s_data = 24'h000000;
`ifdef ADS1675_EMU_RAMP_EN
    e.word = '0; e.und = 1'b0;
`else
    e.word = 24'hFFFFFF; e.und = 1'b1;
`endif
    sbq.push_back(e);
    mon_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    chk("rerise_sclk_low", {31'd0, sclk}, 0);
    @(posedge clk); #1;
    chk("rerise_sclk_high", {31'd0, sclk}, 1);
    chk("rerise_drdy", {31'd0, drdy}, 1);
    chk("rerise_dout_msb", {31'd0, dout}, {31'd0, e.word[DW-1]});
    chk("rerise_frame_cnt", {16'd0, frame_cnt}, 1);
    repeat (100) @(negedge clk);
    mon_en = 1'b0;

    // Power-down keeps the interface quiet.
    pown = 1'b0;
    sclk_ones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (sclk) sclk_ones++;
    end
    chk("pown_sclk_quiet", sclk_ones, 0);
    chk("pown_frame_cnt", {16'd0, frame_cnt}, 0);

    // Reset at bit 5; hold register clears, so the next frame sends zero.
    @(negedge clk);
    pown = 1'b1;
    wait_fs(cyc_w, ok);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_sclk", {31'd0, sclk}, 0);
    chk("midrst_drdy", {31'd0, drdy}, 0);
    chk("midrst_dout", {31'd0, dout}, 0);
    chk("midrst_frame_cnt", {16'd0, frame_cnt}, 0);
    chk("midrst_s_ready", {31'd0, sif.s_ready}, 0);
    @(negedge clk);
    e.word = '0;
`ifdef ADS1675_EMU_RAMP_EN
    e.und = 1'b0;
`else
    e.und = 1'b1;
`endif
    sbq.push_back(e);
    mon_en = 1'b1;
    rst = 1'b0;
    wait_fs(cyc_w, ok);
    chk("post_rst_latency", cyc_w, 2);
    chk("post_rst_frame_cnt", {16'd0, frame_cnt}, 1);
    repeat (100) @(negedge clk);
    mon_en = 1'b0;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ads1675_tx_emulator.md
Name: ads1675_tx_emulator

Overview:
- Transmit-side model of the ADS1675 serial output interface: generates sclk, drdy and dout from parallel samples supplied over a valid/ready handshake.
- Drives the ADS1675 capture path (board loopback through external LVDS buffers, or simulation) so acquisition can be exercised without the ADC fitted.
- Responds to the capture side's control outputs (start, pown, cs_n) the way the converter does.

Parameters:
- DW, 24, sample width in bits; serialised MSB first.
- SCLK_DIV, 2, clk cycles per sclk half-period; must be >= 1.
- FRAME_SCLK, 32, sclk periods per conversion frame; must be >= DW+1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable.
- start  in  1  conversion start from the capture side; active high.
- pown  in  1  power-down, active low; 0 = powered down.
- cs_n  in  1  chip select, active low; gates dout only.
- s_data  in  DW  sample to transmit, signed.
- s_valid  in  1  s_data valid.
- s_ready  out  1  sample accepted this cycle when s_valid is also high.
- sclk  out  1  serial clock.
- drdy  out  1  data-ready strobe, active high, one sclk period wide.
- dout  out  1  serial data.
- underrun  out  1  one-clk pulse: a frame started with no sample available.
- frame_cnt  out  16  frames started since run rose; wraps at 0xFFFF.

Behaviour:
- Reset: sclk=0, drdy=0, dout=0, s_ready=0, underrun=0, frame_cnt=0, hold register=0, div_cnt=0, bit_cnt=FRAME_SCLK-1.
- Reset is only synchronous; rst=1 in mid-frame takes effect at the next edge with the values above.
- run = en & start & pown. States: IDLE (run=0) and RUN.
- IDLE: sclk, drdy, dout, underrun held 0. div_cnt=0, bit_cnt=FRAME_SCLK-1, frame_cnt=0. s_ready=0.
- RUN: div_cnt counts 0..SCLK_DIV-1. At the edge where div_cnt==SCLK_DIV-1, sclk toggles and div_cnt wraps to 0. sclk period = 2*SCLK_DIV clk.
- Rising event = the edge where sclk goes 0->1. At each rising event, bit_cnt increments and wraps from FRAME_SCLK-1 to 0.
- Frame start is the rising event where bit_cnt wraps to 0:
  - s_ready is a combinational decode of registered state, high for exactly the one clk cycle before that edge (div_cnt==SCLK_DIV-1, sclk=0, bit_cnt==FRAME_SCLK-1, run=1).
  - If s_valid=1 in that cycle, s_data is loaded into the hold/shift register at that edge.
  - Otherwise the previous hold value is retransmitted and underrun pulses for one clk.
  - drdy=1 and dout=bit DW-1, both at that same edge (zero added latency).
  - frame_cnt increments at that edge.
- Later rising events: bit_cnt k in 1..DW-1 drives dout = bit DW-1-k. bit_cnt >= DW drives dout=0. drdy returns to 0 at the rising event with bit_cnt=1.
- dout and drdy change only on sclk rising events; the receiver captures on sclk falling edges.
- cs_n=1 forces dout=0 but the frame sequence keeps running. drdy and sclk are unaffected.
- First frame after run rises starts at the first rising event, i.e. SCLK_DIV clk after run rises.
- run falling mid-frame returns to IDLE at the next edge and aborts the frame; it is never completed. The hold register is retained.
- s_ready is never high outside the frame-start cycle. s_valid held high elsewhere has no effect.

Optional Feature:
- Macro ADS1675_EMU_RAMP_EN.
- Defined: an internal DW-bit counter replaces s_data as the source. It starts at 0 on entry to RUN and increments by 1 per frame, wrapping modulo 2^DW. s_ready still pulses, s_valid is ignored, underrun stays 0.
- Not defined: samples come only from s_data; no ramp logic is built.

Test Plan (all with DW=24, SCLK_DIV=2, FRAME_SCLK=32; sclk period 4 clk, frame 128 clk):
- Nominal: en=start=pown=1, cs_n=0, s_valid=1, s_data=0xA5C3F0 -> dout bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1,1,1,1,1,0,0,0,0; drdy high for 4 clk aligned with MSB; then 8 zero bits; next drdy 128 clk later; frame_cnt=1.
- Underrun: one frame with 0x000001, then s_valid=0 -> second frame repeats 0x000001, underrun pulses once (1 clk) at the second frame start, frame_cnt=2.
- Abort: drop start at bit_cnt=10 -> next edge sclk=drdy=dout=0; on start re-rise, first sclk rise after 2 clk and a full new frame with drdy=1.
- cs_n=1 during a 0xFFFFFF frame -> dout stays 0; drdy and sclk toggle normally; s_ready still pulses.
- Reset mid-frame: rst=1 at bit 5 -> all outputs at reset values on the next edge; after rst=0 with run=1, first frame start 2 clk later.
- With ADS1675_EMU_RAMP_EN: 4 frames -> serialised samples 0x000000, 0x000001, 0x000002, 0x000003 regardless of s_data.
